uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
UART transmitter. It serializes one byte per frame onto a single line: start bit, 8 data bits LSB first, optional parity bit, stop bit. It is the transmit counterpart of the system's UART receiver and shares its prescale, parity-enable and parity-type configuration semantics. It sits between the system's TX data source (FIFO/register file) and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 5, width of the prescale input.

Ports:
- UartTx_CLK  input  1  single clock for the whole block.
- UartTx_RST  input  1  reset. One clock; reset is synchronous and active-low.
- UartTx_prescale  input  PRESCALE_WIDTH  clocks per bit; sampled at frame accept.
- UartTx_PAR_EN  input  1  1 = parity bit inserted; sampled at frame accept.
- UartTx_Par_Type  input  1  0 = even, 1 = odd; sampled at frame accept.
- UartTx_PDATA  input  DATA_WIDTH  byte to send; sampled at frame accept.
- UartTx_Data_Valid  input  1  request to send UartTx_PDATA.
- UartTx_TX_OUT  output  1  serial line, idle high, registered.
- UartTx_Busy  output  1  high while a frame is on the line, registered.

Behaviour:
- Reset: when UartTx_RST=0 at a rising edge, the block enters IDLE. UartTx_TX_OUT=1, UartTx_Busy=0, and all counters and latches clear. This applies at any point, including mid-frame; there is no partial stop bit.
- Accept: in IDLE, UartTx_Data_Valid=1 at edge N latches PDATA, PAR_EN, Par_Type and prescale.
  - Effective bit period P = prescale, except prescale=0, which is treated as P=1.
  - Parity is computed from the latched byte: even = XOR of the bits, odd = inverted XOR.
- UartTx_Data_Valid is ignored in every non-IDLE state. No queuing; inputs may change freely after accept.
- States: IDLE -> START -> DATA -> (PARITY if PAR_EN latched) -> STOP -> IDLE.
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0 for P cycles.
  - DATA: TX_OUT=data[bit_cnt] for P cycles per bit. bit_cnt runs 0..DATA_WIDTH-1 (LSB first).
  - PARITY: TX_OUT=parity bit for P cycles.
  - STOP: TX_OUT=1 for P cycles.
- Counters: the edge counter runs 0..P-1 within each bit and wraps to 0 on bit advance. The bit counter increments only in DATA, on edge-counter wrap.
- Latency: after accept at edge N, TX_OUT and Busy take their frame values from edge N+1 (TX_OUT=0 for start, Busy=1).
- Frame length: Busy is high for exactly (DATA_WIDTH+2)*P cycles, or (DATA_WIDTH+3)*P with parity. That is 80 cycles for P=8 without parity and 88 with parity.
- End of frame: Busy falls on the edge following the last STOP cycle, and TX_OUT stays 1.
- Back-to-back frames: Data_Valid held high through the frame end is accepted on the first IDLE cycle. This guarantees a minimum of 1 idle-high cycle between frames.
- Busy and TX_OUT are glitch-free registered outputs with no combinational paths from the inputs.

Test Plan:
- Reset held low for 3 cycles -> TX_OUT=1 and Busy=0. Release with Data_Valid=0 -> outputs remain 1/0 indefinitely.
- PDATA=8'hA5, PAR_EN=0, prescale=8, Data_Valid pulse for 1 cycle:
  - TX_OUT bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - Busy is high for 80 cycles starting the cycle after accept.
- PDATA=8'hA5, PAR_EN=1, prescale=16:
  - Par_Type=0 -> parity bit 0.
  - Par_Type=1 -> parity bit 1.
  - Busy is high for 176 cycles in both cases.
- Frame in progress with PDATA=8'h3C; at cycle 20 apply Data_Valid=1 with PDATA=8'hFF -> ignored; the line carries only 8'h3C and the next frame does not start.
- Data_Valid held high with PDATA=8'h01 then 8'h80, prescale=4, no parity:
  - Two frames of 40 Busy cycles each.
  - Exactly 1 cycle of TX_OUT=1 with Busy=0 between them.
- prescale=0 with PDATA=8'h55 -> each bit lasts 1 cycle, giving a 10-cycle frame.
- Reset asserted mid-DATA at bit 3 -> TX_OUT=1 and Busy=0 on the next edge; the next accepted frame is transmitted normally.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core
// UART transmitter: serializes one byte per frame as start bit, DATA_WIDTH
// data bits LSB first, an optional parity bit and one stop bit. Prescale,
// parity enable and parity type use the same meaning as in the matching
// receiver.
//
// Ports:
//   UartTx_CLK         clock
//   UartTx_RST         synchronous reset, active low
//   UartTx_prescale    clocks per bit (0 is treated as 1), sampled at accept
//   UartTx_PAR_EN      1 = insert a parity bit, sampled at accept
//   UartTx_Par_Type    0 = even, 1 = odd parity, sampled at accept
//   UartTx_PDATA       byte to send, sampled at accept
//   UartTx_Data_Valid  send request, only honoured in IDLE
//   UartTx_TX_OUT      registered serial line, idle high
//   UartTx_Busy        registered, high while a frame is on the line
module uart_tx_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      UartTx_CLK,
  input  logic                      UartTx_RST,
  input  logic [PRESCALE_WIDTH-1:0] UartTx_prescale,
  input  logic                      UartTx_PAR_EN,
  input  logic                      UartTx_Par_Type,
  input  logic [DATA_WIDTH-1:0]     UartTx_PDATA,
  input  logic                      UartTx_Data_Valid,
  output logic                      UartTx_TX_OUT,
  output logic                      UartTx_Busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] period_m1_q, period_m1_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_end;

  // Last clock of the current bit period.
  assign bit_end = (edge_cnt_q == period_m1_q);

  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    period_m1_d = period_m1_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;

    unique case (state_q)
      S_IDLE: begin
        if (UartTx_Data_Valid) begin
          data_d      = UartTx_PDATA;
          par_en_d    = UartTx_PAR_EN;
          // Parity is resolved once here so the line never depends on
          // inputs that may change during the frame.
          par_bit_d   = (^UartTx_PDATA) ^ UartTx_Par_Type;
          period_m1_d = (UartTx_prescale == '0) ? '0 : UartTx_prescale - 1'b1;
          edge_cnt_d  = '0;
          bit_cnt_d   = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          edge_cnt_d = '0;
          state_d    = S_DATA;
        end else begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          edge_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          edge_cnt_d = '0;
          state_d    = S_STOP;
        end else begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          edge_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the current state one register later, so the line
    // changes the cycle after accept and every bit keeps its full period.
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_cnt_q];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge UartTx_CLK) begin
    if (!UartTx_RST) begin
      state_q     <= S_IDLE;
      edge_cnt_q  <= '0;
      period_m1_q <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      period_m1_q <= period_m1_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign UartTx_TX_OUT = tx_q;
  assign UartTx_Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core
// Directed bench for uart_tx_core: a table of frames with hand-computed
// line patterns, plus hand-written sequences for reset, ignored requests,
// back-to-back frames and reset in the middle of a frame.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [4:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] pdata;
  logic       data_valid;
  logic       tx_out;
  logic       busy;

  int n_checks;
  int n_fails;

  uart_tx_core #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(5)
  ) dut (
    .UartTx_CLK       (clk),
    .UartTx_RST       (rst),
    .UartTx_prescale  (prescale),
    .UartTx_PAR_EN    (par_en),
    .UartTx_Par_Type  (par_type),
    .UartTx_PDATA     (pdata),
    .UartTx_Data_Valid(data_valid),
    .UartTx_TX_OUT    (tx_out),
    .UartTx_Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line pattern: bit 0 = start, bits 1..8 = data LSB first,
  // then parity (if enabled), then stop.
  typedef struct {
    string      name;
    logic [7:0] pdata;
    logic       par_en;
    logic       par_type;
    logic [4:0] prescale;
    int         nbits;
    int         p;
    int         busy_len;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_tx"}, 32'(tx_out), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Present a request at a falling edge; it is accepted on the next rising
  // edge. Outputs must still be idle in the cycle after that edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [4:0] ps, input bit keep_valid,
                      input logic [7:0] next_d, input string nm);
    pdata      = d;
    par_en     = pe;
    par_type   = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) data_valid = 1'b0;
    pdata = next_d;
    chk_idle({nm, "_accept"});
    @(negedge clk);
  endtask

  // Check every busy cycle of a frame, then the first cycle after it.
  task automatic check_frame(input logic [10:0] frame, input int p,
                             input int len, input int inject_at,
                             input string nm);
    for (int c = 0; c < len; c++) begin
      if (c == inject_at) begin
        data_valid = 1'b1;
        pdata      = 8'hFF;
      end
      if (c == inject_at + 1) data_valid = 1'b0;
      chk($sformatf("%s_tx_c%0d", nm, c), 32'(tx_out), 32'(frame[c / p]));
      chk($sformatf("%s_busy_c%0d", nm, c), 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk_idle({nm, "_end"});
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b0;
    prescale   = 5'd8;
    par_en     = 1'b0;
    par_type   = 1'b0;
    pdata      = 8'h00;
    data_valid = 1'b0;

    vecs[0] = '{"a5_p8",      8'hA5, 1'b0, 1'b0, 5'd8,  10, 8,  80,  11'b0_1_10100101_0};
    vecs[1] = '{"a5_even_p16",8'hA5, 1'b1, 1'b0, 5'd16, 11, 16, 176, 11'b1_0_10100101_0};
    vecs[2] = '{"a5_odd_p16", 8'hA5, 1'b1, 1'b1, 5'd16, 11, 16, 176, 11'b1_1_10100101_0};
    vecs[3] = '{"55_p0",      8'h55, 1'b0, 1'b0, 5'd0,  10, 1,  10,  11'b0_1_01010101_0};
    vecs[4] = '{"00_odd_p2",  8'h00, 1'b1, 1'b1, 5'd2,  11, 2,  22,  11'b1_1_00000000_0};
    vecs[5] = '{"ff_even_p3", 8'hFF, 1'b1, 1'b0, 5'd3,  11, 3,  33,  11'b1_0_11111111_0};
    vecs[6] = '{"96_p1",      8'h96, 1'b0, 1'b0, 5'd1,  10, 1,  10,  11'b0_1_10010110_0};

    // Reset held for three cycles, then released with no request.
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("post_reset_%0d", i));
    end

    // Table of single frames.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].pdata, vecs[v].par_en, vecs[v].par_type, vecs[v].prescale,
           1'b0, vecs[v].pdata, vecs[v].name);
      check_frame(vecs[v].frame, vecs[v].p, vecs[v].busy_len, -10, vecs[v].name);
      repeat (2) @(negedge clk);
    end

    // Request during a frame is ignored and never queued.
    send(8'h3C, 1'b0, 1'b0, 5'd8, 1'b0, 8'h3C, "ign");
    check_frame(11'b0_1_00111100_0, 8, 80, 20, "ign");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle($sformatf("ign_after_%0d", i));
    end

    // Back-to-back frames with the request held high.
    send(8'h01, 1'b0, 1'b0, 5'd4, 1'b1, 8'h80, "b2b1");
    check_frame(11'b0_1_00000001_0, 4, 40, -10, "b2b1");
    @(negedge clk);
    data_valid = 1'b0;
    check_frame(11'b0_1_10000000_0, 4, 40, -10, "b2b2");
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 3 (start 8 + bits 0..2 = 32 cycles).
    send(8'hA5, 1'b0, 1'b0, 5'd8, 1'b0, 8'hA5, "mid");
    repeat (34) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_tx_bit3", 32'(tx_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle($sformatf("mid_idle_%0d", i));
    end
    send(8'h3C, 1'b0, 1'b0, 5'd2, 1'b0, 8'h3C, "after_rst");
    check_frame(11'b0_1_00111100_0, 2, 20, -10, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
